cache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller that sits directly upstream of the status/tag RAM and data RAM. It accepts single-word load/store requests from the core and issues one-cycle read/write pulses to both RAMs. It compares tags, returns hit data, and on a miss writes back a dirty victim line before refilling from the memory interface. It owns all sequencing; the RAMs are plain synchronous storage behind it.

---
 rtl/cache_controller_if.sv | 56 +++++
 rtl/cache_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_cache_controller.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// Bundle of core, tag/data RAM and memory-side signals around the cache controller.
// The controller uses the slave modport; the surrounding system uses master.
interface cache_controller_if #(
    parameter int TAG_LEN    = 13,
    parameter int INDEX_LEN  = 10,
    parameter int OFFSET_LEN = 4
);
    localparam int ADDR_W = TAG_LEN + INDEX_LEN + OFFSET_LEN;
    localparam int LINE_W = 32 << (OFFSET_LEN - 2);

    logic                         req_valid;
    logic                         req_we;
    logic [ADDR_W-1:0]            req_addr;
    logic [31:0]                  req_wdata;
    logic                         req_ready;
    logic                         rsp_valid;
    logic [31:0]                  rsp_rdata;

    logic [INDEX_LEN-1:0]         ram_addr;
    logic                         tag_re;
    logic                         tag_we;
    logic                         data_re;
    logic                         data_we;
    logic [TAG_LEN-1:0]           tag_wr;
    logic [2:0]                   status_wr;
    logic [TAG_LEN-1:0]           tag_rd;
    logic [2:0]                   status_rd;
    logic [LINE_W-1:0]            data_wr;
    logic [LINE_W-1:0]            data_rd;

    logic                         mem_req_valid;
    logic                         mem_req_we;
    logic [TAG_LEN+INDEX_LEN-1:0] mem_req_addr;
    logic [LINE_W-1:0]            mem_wdata;
    logic                         mem_req_ready;
    logic                         mem_rsp_valid;
    logic [LINE_W-1:0]            mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata,
        output ram_addr, tag_re, tag_we, data_re, data_we, tag_wr, status_wr, data_wr,
        input  tag_rd, status_rd, data_rd,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ram_addr, tag_re, tag_we, data_re, data_we, tag_wr, status_wr, data_wr,
        output tag_rd, status_rd, data_rd,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller: tag compare, hit service,
// dirty-victim writeback and line refill, sequencing the external tag/status and data RAMs.
module cache_controller #(
    parameter int TAG_LEN    = 13,
    parameter int INDEX_LEN  = 10,
    parameter int OFFSET_LEN = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    cache_controller_if.slave bus_io
);
    localparam int ADDR_W = TAG_LEN + INDEX_LEN + OFFSET_LEN;
    localparam int WORD_W = OFFSET_LEN - 2;
    localparam int LINE_W = 32 << WORD_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_FILL_REQ  = 3'd3,
        S_FILL_WAIT = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [TAG_LEN-1:0]   tag_q, tag_d;
    logic [INDEX_LEN-1:0] index_q, index_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [TAG_LEN-1:0]   victim_tag_q, victim_tag_d;
    logic [LINE_W-1:0]    victim_line_q, victim_line_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;

    logic [TAG_LEN-1:0]   req_tag_s;
    logic [INDEX_LEN-1:0] req_index_s;
    logic [WORD_W-1:0]    req_word_s;
    logic                 hit_s;
    logic                 victim_dirty_s;
    logic                 unused_s;

    function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line,
                                             input logic [WORD_W-1:0] sel);
        return line[32*int'(sel) +: 32];
    endfunction

    function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_W-1:0] sel,
                                                   input logic [31:0]       wdata);
        logic [LINE_W-1:0] res;
        res = line;
        res[32*int'(sel) +: 32] = wdata;
        return res;
    endfunction

    assign req_tag_s      = bus_io.req_addr[ADDR_W-1 -: TAG_LEN];
    assign req_index_s    = bus_io.req_addr[INDEX_LEN+OFFSET_LEN-1 -: INDEX_LEN];
    assign req_word_s     = bus_io.req_addr[OFFSET_LEN-1:2];
    assign hit_s          = bus_io.status_rd[0] && (bus_io.tag_rd == tag_q);
    assign victim_dirty_s = bus_io.status_rd[0] && bus_io.status_rd[1];
    assign unused_s       = ^{bus_io.req_addr[1:0], bus_io.status_rd[2]};

    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus_io.req_valid) state_d = S_LOOKUP;
                else                  state_d = S_IDLE;
            end
            S_LOOKUP: begin
                if (hit_s)               state_d = S_IDLE;
                else if (victim_dirty_s) state_d = S_WRITEBACK;
                else                     state_d = S_FILL_REQ;
            end
            S_WRITEBACK: begin
                if (bus_io.mem_req_ready) state_d = S_FILL_REQ;
                else                      state_d = S_WRITEBACK;
            end
            S_FILL_REQ: begin
                if (bus_io.mem_req_ready) state_d = S_FILL_WAIT;
                else                      state_d = S_FILL_REQ;
            end
            S_FILL_WAIT: begin
                if (bus_io.mem_rsp_valid) state_d = S_IDLE;
                else                      state_d = S_FILL_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: RAM strobes, memory request and next values of the latched datapath
    always_comb begin
        bus_io.req_ready     = 1'b0;
        bus_io.ram_addr      = index_q;
        bus_io.tag_re        = 1'b0;
        bus_io.data_re       = 1'b0;
        bus_io.tag_we        = 1'b0;
        bus_io.data_we       = 1'b0;
        bus_io.tag_wr        = tag_q;
        bus_io.status_wr     = 3'b000;
        bus_io.data_wr       = '0;
        bus_io.mem_req_valid = 1'b0;
        bus_io.mem_req_we    = 1'b0;
        bus_io.mem_req_addr  = {tag_q, index_q};
        bus_io.mem_wdata     = victim_line_q;
        we_d                 = we_q;
        tag_d                = tag_q;
        index_d              = index_q;
        word_d               = word_q;
        wdata_d              = wdata_q;
        victim_tag_d         = victim_tag_q;
        victim_line_d        = victim_line_q;
        rsp_valid_d          = 1'b0;
        rsp_rdata_d          = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                // reset_ni gating keeps ready and RAM reads quiet while reset is held
                bus_io.req_ready = reset_ni;
                bus_io.ram_addr  = req_index_s;
                if (bus_io.req_valid && reset_ni) begin
                    bus_io.tag_re  = 1'b1;
                    bus_io.data_re = 1'b1;
                    we_d           = bus_io.req_we;
                    tag_d          = req_tag_s;
                    index_d        = req_index_s;
                    word_d         = req_word_s;
                    wdata_d        = bus_io.req_wdata;
                end else begin
                    bus_io.tag_re  = 1'b0;
                    bus_io.data_re = 1'b0;
                end
            end
            S_LOOKUP: begin
                if (hit_s) begin
                    rsp_valid_d = 1'b1;
                    if (we_q) begin
                        bus_io.tag_we    = 1'b1;
                        bus_io.data_we   = 1'b1;
                        bus_io.status_wr = 3'b011;
                        bus_io.data_wr   = put_word(bus_io.data_rd, word_q, wdata_q);
                        rsp_rdata_d      = 32'h0000_0000;
                    end else begin
                        rsp_rdata_d = get_word(bus_io.data_rd, word_q);
                    end
                end else if (victim_dirty_s) begin
                    victim_tag_d  = bus_io.tag_rd;
                    victim_line_d = bus_io.data_rd;
                end else begin
                    victim_line_d = victim_line_q;
                end
            end
            S_WRITEBACK: begin
                bus_io.mem_req_valid = 1'b1;
                bus_io.mem_req_we    = 1'b1;
                bus_io.mem_req_addr  = {victim_tag_q, index_q};
            end
            S_FILL_REQ: begin
                bus_io.mem_req_valid = 1'b1;
            end
            S_FILL_WAIT: begin
                if (bus_io.mem_rsp_valid) begin
                    bus_io.tag_we  = 1'b1;
                    bus_io.data_we = 1'b1;
                    rsp_valid_d    = 1'b1;
                    if (we_q) begin
                        bus_io.status_wr = 3'b011;
                        bus_io.data_wr   = put_word(bus_io.mem_rdata, word_q, wdata_q);
                        rsp_rdata_d      = 32'h0000_0000;
                    end else begin
                        bus_io.status_wr = 3'b001;
                        bus_io.data_wr   = bus_io.mem_rdata;
                        rsp_rdata_d      = get_word(bus_io.mem_rdata, word_q);
                    end
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Request latches, victim buffer and registered response
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            we_q          <= 1'b0;
            tag_q         <= '0;
            index_q       <= '0;
            word_q        <= '0;
            wdata_q       <= 32'h0000_0000;
            victim_tag_q  <= '0;
            victim_line_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0000_0000;
        end else begin
            we_q          <= we_d;
            tag_q         <= tag_d;
            index_q       <= index_d;
            word_q        <= word_d;
            wdata_q       <= wdata_d;
            victim_tag_q  <= victim_tag_d;
            victim_line_q <= victim_line_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: RAM and memory models around the controller, checked against
// an abstract cache/memory reference model under directed and randomized traffic.
module tb_cache_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    cache_controller_if bus ();

    cache_controller dut (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .bus_io  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- tag/status and data RAMs ----------------
    logic [12:0]  tag_mem [1024];
    logic [2:0]   st_mem  [1024];
    logic [127:0] dat_mem [1024];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) begin
                tag_mem[i] <= 13'h0;
                st_mem[i]  <= 3'b000;
                dat_mem[i] <= 128'h0;
            end
        end else begin
            if (bus.tag_re) begin
                bus.tag_rd    <= tag_mem[bus.ram_addr];
                bus.status_rd <= st_mem[bus.ram_addr];
            end
            if (bus.tag_we) begin
                tag_mem[bus.ram_addr] <= bus.tag_wr;
                st_mem[bus.ram_addr]  <= bus.status_wr;
            end
            if (bus.data_re) bus.data_rd <= dat_mem[bus.ram_addr];
            if (bus.data_we) dat_mem[bus.ram_addr] <= bus.data_wr;
        end
    end

    // ---------------- main memory (environment) ----------------
    logic [127:0] env_mem [bit [22:0]];
    int           force_delay = -1;
    bit           hold_rsp = 1'b0;
    bit           release_rsp = 1'b0;
    bit           fill_accepted = 1'b0;
    int           wb_cnt = 0;
    int           rd_cnt = 0;
    logic [22:0]  wb_addr, rd_addr;
    logic [127:0] wb_data;

    function automatic logic [127:0] init_line(input logic [22:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = {7'h55, la, 2'(w)};
        return l;
    endfunction

    function automatic logic [127:0] env_line(input logic [22:0] la);
        if (env_mem.exists(la)) return env_mem[la];
        return init_line(la);
    endfunction

    initial begin : mem_responder
        int           dly;
        logic [22:0]  la;
        logic [127:0] line;
        logic         we;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 128'h0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_req_valid) begin
                la   = bus.mem_req_addr;
                we   = bus.mem_req_we;
                line = bus.mem_wdata;
                dly  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                for (int i = 0; i < dly; i++) begin
                    @(negedge clk);
                    check_eq("mreq_hold_v", bus.mem_req_valid, 1'b1);
                    check_eq("mreq_hold_addr", bus.mem_req_addr, la);
                    check_eq("mreq_hold_we", bus.mem_req_we, we);
                    if (we) check_eq("mreq_hold_data", bus.mem_wdata, line);
                end
                bus.mem_req_ready = 1'b1;
                @(negedge clk);
                bus.mem_req_ready = 1'b0;
                if (we) begin
                    wb_cnt++;
                    wb_addr     = la;
                    wb_data     = line;
                    env_mem[la] = line;
                end else begin
                    rd_cnt++;
                    rd_addr       = la;
                    fill_accepted = 1'b1;
                    if (hold_rsp) begin
                        for (int k = 0; k < 5000 && !release_rsp; k++) @(negedge clk);
                    end else begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                    end
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rdata     = env_line(la);
                    @(negedge clk);
                    bus.mem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // RAM read and write strobes must never overlap, and tag/data strobes travel together
    always @(negedge clk) begin
        if (bus.tag_re || bus.tag_we || bus.data_re || bus.data_we) begin
            check_eq("ram_rw_excl", (bus.tag_re | bus.data_re) & (bus.tag_we | bus.data_we), 1'b0);
            check_eq("ram_strobe_pair", {bus.tag_re, bus.tag_we}, {bus.data_re, bus.data_we});
        end
    end

    // ---------------- reference model: ideal cache over a flat line memory ----------------
    bit           m_valid [1024];
    bit           m_dirty [1024];
    logic [12:0]  m_tag   [1024];
    logic [127:0] m_line  [1024];
    logic [127:0] m_mem   [bit [22:0]];

    function automatic logic [127:0] model_mem_line(input logic [22:0] la);
        if (m_mem.exists(la)) return m_mem[la];
        return init_line(la);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic model_access(input bit we, input logic [26:0] addr, input logic [31:0] wd,
                                output bit hit, output bit exp_wb, output logic [22:0] wb_la,
                                output logic [127:0] wb_line, output logic [22:0] rd_la,
                                output logic [31:0] rdata);
        int          idx;
        int          w;
        logic [12:0] tg;
        idx     = int'(addr[13:4]);
        w       = int'(addr[3:2]);
        tg      = addr[26:14];
        rd_la   = addr[26:4];
        hit     = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb  = 1'b0;
        wb_la   = 23'h0;
        wb_line = 128'h0;
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_wb        = 1'b1;
                wb_la         = {m_tag[idx], 10'(idx)};
                wb_line       = m_line[idx];
                m_mem[wb_la]  = m_line[idx];
            end
            m_line[idx]  = model_mem_line(rd_la);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            m_line[idx][32*w +: 32] = wd;
            m_dirty[idx] = 1'b1;
            rdata = 32'h0;
        end else begin
            rdata = m_line[idx][32*w +: 32];
        end
    endtask

    // ---------------- request driver ----------------
    task automatic do_req(input bit we, input logic [26:0] addr, input logic [31:0] wd);
        bit           hit, exp_wb;
        logic [22:0]  wb_la, rd_la;
        logic [127:0] wb_line;
        logic [31:0]  rdata;
        int           wb0, rd0, lat, idx;
        model_access(we, addr, wd, hit, exp_wb, wb_la, wb_line, rd_la, rdata);
        idx = int'(addr[13:4]);
        wb0 = wb_cnt;
        rd0 = rd_cnt;
        @(negedge clk);
        check_eq("req_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) begin
            check_eq("rsp_timeout", 1'b0, 1'b1);
            return;
        end
        check_eq(we ? "store_rdata" : "load_rdata", bus.rsp_rdata, rdata);
        if (hit) begin
            check_eq("hit_latency", lat, 2);
            check_eq("hit_no_fill", rd_cnt - rd0, 0);
            check_eq("hit_no_wb", wb_cnt - wb0, 0);
        end else begin
            check_eq("miss_fill_cnt", rd_cnt - rd0, 1);
            check_eq("fill_addr", rd_addr, rd_la);
            check_eq("wb_cnt", wb_cnt - wb0, int'(exp_wb));
            if (exp_wb) begin
                check_eq("wb_addr", wb_addr, wb_la);
                check_eq("wb_line", wb_data, wb_line);
            end
        end
        @(negedge clk);
        check_eq("rsp_one_pulse", bus.rsp_valid, 1'b0);
        check_eq("ram_status", st_mem[idx], {1'b0, m_dirty[idx], 1'b1});
        check_eq("ram_tag", tag_mem[idx], m_tag[idx]);
        check_eq("ram_line", dat_mem[idx], m_line[idx]);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [12:0] tags [4];
        logic [26:0] a;
        int          r, k;
        tags[0] = 13'h0000;
        tags[1] = 13'h0001;
        tags[2] = 13'h1000;
        tags[3] = 13'h1FFF;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 27'h0;
        bus.req_wdata = 32'h0;
        model_reset();
        env_mem[23'h1] = {32'hD, 32'hC, 32'hB, 32'hA};
        m_mem[23'h1]   = {32'hD, 32'hC, 32'hB, 32'hA};

        repeat (1100) @(negedge clk);
        check_eq("rst_req_ready", bus.req_ready, 1'b0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst_mem_req", bus.mem_req_valid, 1'b0);
        check_eq("rst_ram_en", {bus.tag_re, bus.tag_we, bus.data_re, bus.data_we}, 4'b0000);
        rst_n = 1'b1;

        do_req(1'b0, 27'h0000010, 32'h0);
        do_req(1'b0, 27'h0000010, 32'h0);
        do_req(1'b0, 27'h0000014, 32'h0);
        do_req(1'b1, 27'h0000014, 32'hCAFEF00D);
        do_req(1'b0, 27'h0000014, 32'h0);
        force_delay = 3;
        do_req(1'b0, 27'h4000010, 32'h0);
        force_delay = -1;
        do_req(1'b1, 27'h0000018, 32'h1234_5678);
        do_req(1'b0, 27'h0000018, 32'h0);

        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 4));
            a = {tags[$urandom_range(0, 3)], (r == 4) ? 10'd1023 : 10'(r),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_req(1'($urandom_range(0, 1)), a, $urandom);
        end

        // reset while waiting for a refill of an untouched index
        hold_rsp      = 1'b1;
        release_rsp   = 1'b0;
        fill_accepted = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = {13'h0AA, 10'd7, 4'h8};
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0;
        while (!fill_accepted && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("fill_reached", fill_accepted, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_req_ready", bus.req_ready, 1'b0);
        check_eq("arst_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("arst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_eq("arst_mem_req", bus.mem_req_valid, 1'b0);
        check_eq("arst_ram_en", {bus.tag_re, bus.tag_we, bus.data_re, bus.data_we}, 4'b0000);
        model_reset();
        repeat (1100) @(negedge clk);
        rst_n = 1'b1;
        release_rsp = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("late_rsp_no_wr", {bus.tag_we, bus.data_we}, 2'b00);
            check_eq("late_rsp_no_rsp", bus.rsp_valid, 1'b0);
        end
        hold_rsp = 1'b0;
        check_eq("post_rst_ready", bus.req_ready, 1'b1);

        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 4));
            a = {tags[$urandom_range(0, 3)], (r == 4) ? 10'd1023 : 10'(r),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_req(1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
